instr_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the `Gambling_Tec` single-cycle core and drives its `Instruction` input.
- Holds the program counter and issues reads to a synchronous instruction ROM.
- Presents one instruction per cycle with a valid flag and its PC.
- Absorbs core stalls through a one-entry skid register, and redirects on taken branches with zero bubble.
- Counts consumed instructions for bring-up and debug.

---
 rtl/instr_fetch_unit.sv | 96 +++++++++
 tb/tb_instr_fetch_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage for the Gambling_Tec core: PC, synchronous ROM read issue, one-entry
// skid register for core stalls, and zero-bubble branch redirect.
//
// Handshake: the instruction on Instruction/instr_pc is offered whenever instr_valid=1
// and is taken by the core in any cycle where stall=0 or branch_taken=1; otherwise the
// same instruction and PC are offered again next cycle.
module instr_fetch_unit #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = 32'hE1A0_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd_en,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       Instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [31:0]       instr_count,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] out_pc_q;
  logic [31:0]       skid_q;
  logic [31:0]       count_q;
  logic              valid_q;

  logic              issue;
  logic              consume;
  logic [ADDR_W-1:0] target_aligned;
  logic [ADDR_W-1:0] issue_addr;
  logic              unused_tgt_lsbs;

  assign target_aligned  = {branch_target[ADDR_W-1:2], 2'b00};
  assign unused_tgt_lsbs = ^branch_target[1:0];

  // A redirect always wins; FETCH issues unconditionally since nothing is presented yet.
  assign issue      = (state_q == ST_FETCH) || branch_taken || !stall;
  assign issue_addr = branch_taken ? target_aligned : pc_q;
  assign consume    = valid_q && (branch_taken || !stall);

  assign imem_rd_en = !rst && issue;
  assign imem_addr  = rst ? RESET_PC : issue_addr;

  always_comb begin
    Instruction = NOP_INSTR;
    case (state_q)
      ST_RUN:  Instruction = imem_rdata;
      ST_HOLD: Instruction = skid_q;
      default: Instruction = NOP_INSTR;
    endcase
  end

  assign instr_valid = valid_q;
  assign instr_pc    = out_pc_q;
  assign instr_count = count_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      valid_q  <= 1'b0;
      pc_q     <= RESET_PC;
      out_pc_q <= RESET_PC;
      skid_q   <= 32'd0;
      count_q  <= 32'd0;
    end else begin
      count_q <= count_q + {31'd0, consume};
      if (issue) begin
        state_q  <= ST_RUN;
        valid_q  <= 1'b1;
        out_pc_q <= issue_addr;
        pc_q     <= issue_addr + PC_STEP;
      end else if (state_q == ST_RUN) begin
        // ROM data is only good this cycle, so capture it before it goes stale.
        skid_q  <= imem_rdata;
        state_q <= ST_HOLD;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: boot, stall/skid, branch, branch-in-hold,
// asynchronous reset during a stall, and PC wrap, against a synchronous ROM model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instr_count;
  logic [1:0]  dbg_state_o;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rd_en    (imem_rd_en),
    .imem_rdata    (imem_rdata),
    .Instruction   (Instruction),
    .instr_valid   (instr_valid),
    .instr_pc      (instr_pc),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_count   (instr_count),
    .dbg_state_o   (dbg_state_o)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: word[i] = 0xE000_0000 + i, garbage when not read
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= 32'hE000_0000 + {2'b00, imem_addr[31:2]};
    else            imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive inputs just after the falling edge, then settle before checking.
  task automatic cyc(input logic s, input logic b, input logic [31:0] t);
    @(negedge clk);
    stall = s;
    branch_taken = b;
    branch_target = t;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] cnt);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    check({tag, "_pc"}, instr_pc, pc);
    check({tag, "_instr"}, Instruction, ins);
    check({tag, "_count"}, instr_count, cnt);
  endtask

  task automatic chk_reset_outs(input string tag);
    check({tag, "_rd_en"}, {31'd0, imem_rd_en}, 32'd0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_instr"}, Instruction, NOP);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_pc"}, instr_pc, 32'h0);
    check({tag, "_count"}, instr_count, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_reset_outs("rst0");

    // Boot
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("boot_fetch_valid", {31'd0, instr_valid}, 32'd0);
    check("boot_fetch_instr", Instruction, NOP);
    check("boot_fetch_rd_en", {31'd0, imem_rd_en}, 32'd1);
    check("boot_fetch_addr", imem_addr, 32'h0);
    cyc(0, 0, 0); chk_out("boot0", 32'h00, 32'hE000_0000, 0);
    check("boot0_addr", imem_addr, 32'h4);
    cyc(0, 0, 0); chk_out("boot1", 32'h04, 32'hE000_0001, 1);
    cyc(0, 0, 0); chk_out("boot2", 32'h08, 32'hE000_0002, 2);
    cyc(0, 0, 0); chk_out("boot3", 32'h0C, 32'hE000_0003, 3);
    cyc(0, 0, 0); chk_out("boot4", 32'h10, 32'hE000_0004, 4);
    // Sixth cycle: redirect back to 8 for the stall test
    cyc(0, 1, 32'h8); chk_out("boot5", 32'h14, 32'hE000_0005, 5);
    check("br8_addr", imem_addr, 32'h8);

    // Stall for three cycles at PC 8
    cyc(1, 0, 0); chk_out("stall0", 32'h08, 32'hE000_0002, 6);
    check("stall0_rd_en", {31'd0, imem_rd_en}, 32'd0);
    cyc(1, 0, 0); chk_out("stall1", 32'h08, 32'hE000_0002, 6);
    check("stall1_state", {30'd0, dbg_state_o}, 32'd2);
    cyc(1, 0, 0); chk_out("stall2", 32'h08, 32'hE000_0002, 6);
    check("stall2_rd_en", {31'd0, imem_rd_en}, 32'd0);
    cyc(0, 0, 0); chk_out("release", 32'h08, 32'hE000_0002, 6);
    check("release_addr", imem_addr, 32'hC);
    check("release_rd_en", {31'd0, imem_rd_en}, 32'd1);
    // Branch to 4, then the spec'd branch at PC 4 to 0x43
    cyc(0, 1, 32'h4); chk_out("after_rel", 32'h0C, 32'hE000_0003, 7);
    cyc(0, 1, 32'h43); chk_out("br_at4", 32'h04, 32'hE000_0001, 8);
    check("br43_addr", imem_addr, 32'h40);
    cyc(0, 0, 0); chk_out("br_tgt", 32'h40, 32'hE000_0010, 9);
    cyc(1, 0, 0); chk_out("br_next", 32'h44, 32'hE000_0011, 10);
    // Branch while held with stall still high
    cyc(1, 1, 32'h80); chk_out("hold_br", 32'h44, 32'hE000_0011, 10);
    check("hold_br_state", {30'd0, dbg_state_o}, 32'd2);
    check("hold_br_addr", imem_addr, 32'h80);
    check("hold_br_rd_en", {31'd0, imem_rd_en}, 32'd1);
    cyc(1, 0, 0); chk_out("hold_br_tgt", 32'h80, 32'hE000_0020, 11);
    check("hold_br_exit_state", {30'd0, dbg_state_o}, 32'd1);
    cyc(1, 0, 0); chk_out("hold2", 32'h80, 32'hE000_0020, 11);

    // Asynchronous reset between edges during HOLD
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outs("async_rst");
    check("async_rst_state", {30'd0, dbg_state_o}, 32'd0);
    @(negedge clk);
    #1;
    chk_reset_outs("rst_held");

    // Restart; stall is ignored in FETCH
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b1;
    #1;
    check("reboot_rd_en", {31'd0, imem_rd_en}, 32'd1);
    check("reboot_addr", imem_addr, 32'h0);
    check("reboot_valid", {31'd0, instr_valid}, 32'd0);
    cyc(0, 0, 0); chk_out("reboot0", 32'h00, 32'hE000_0000, 0);
    // Wrap: target low bits are ignored
    cyc(0, 1, 32'hFFFF_FFFF); chk_out("reboot1", 32'h04, 32'hE000_0001, 1);
    check("wrap_br_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0); chk_out("wrap0", 32'hFFFF_FFFC, 32'h1FFF_FFFF, 2);
    check("wrap0_addr", imem_addr, 32'h0);
    cyc(0, 0, 0); chk_out("wrap1", 32'h0000_0000, 32'hE000_0000, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
